dcache_responder: RTL
=====================

Name: dcache_responder

Overview:
Responder end of the CPU data-memory port driven by the MEM stage (address, write data, read data).
- Direct-mapped, write-back, write-allocate data cache.
- Serves word reads and byte-enabled writes from the pipeline.
- Fills and evicts 256-bit lines over the physical-memory line interface.
- Sits between MEM and the memory arbiter/cacheline adaptor.

Parameters:
S_INDEX, 3, set-index bits (2^S_INDEX sets; 32-byte lines; tag = 27 - S_INDEX bits)

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
mem_address  input  32  CPU byte address; bits [1:0] ignored
mem_read  input  1  read request; held stable until mem_resp
mem_write  input  1  write request; held stable until mem_resp
mem_byte_enable  input  4  write byte lanes
mem_wdata  input  32  write data
mem_rdata  output  32  read data; valid when mem_resp=1
mem_resp  output  1  one-cycle completion pulse
pmem_address  output  32  line address; bits [4:0]=0
pmem_read  output  1  line fill request
pmem_write  output  1  line writeback request
pmem_wdata  output  256  evicted line
pmem_rdata  input  256  filled line
pmem_resp  input  1  one-cycle completion from memory

Behaviour:
Address split:
- word = addr[4:2]
- set = addr[4+S_INDEX:5]
- tag = addr[31:5+S_INDEX]

Reset (clk edge with rst=1):
- State goes to IDLE; all valid and dirty bits clear.
- mem_resp, pmem_read and pmem_write are 0.
- mem_rdata, pmem_wdata and pmem_address are 0.
- Tag and data arrays are not cleared.

FSM states:
- IDLE: if mem_read|mem_write, go to COMPARE; the arrays are read at this set.
- COMPARE, hit (valid && tag match):
  - mem_resp=1 for exactly one cycle.
  - Read: mem_rdata = line word[word].
  - Write: merge mem_wdata into word[word] per mem_byte_enable; set dirty; commit at the end of the cycle.
  - Then go to IDLE.
- COMPARE, miss with valid && dirty: go to WRITEBACK. Miss otherwise: go to FILL.
- WRITEBACK:
  - Hold pmem_write=1 with pmem_address={stored tag, set, 5'b0} and pmem_wdata=stored line, all stable.
  - On pmem_resp go to FILL; pmem_write drops the next cycle.
- FILL:
  - Hold pmem_read=1 with pmem_address={tag, set, 5'b0}.
  - On pmem_resp write the line, tag, valid=1 and dirty=0, then go to COMPARE. The retry always hits.

Latency:
- Hit: request seen at cycle 0, mem_resp at cycle 1.
- Clean miss: mem_resp 2 cycles after pmem_resp.
- Dirty miss: one additional memory round-trip.

Rules:
- pmem_read and pmem_write are never both 1.
- mem_resp is never asserted outside COMPARE.
- If mem_read and mem_write are both 1, the request is treated as a write.
- Write hit with byte_enable=0: mem_resp is asserted, data is unchanged, dirty is still set.
- Reset mid-WRITEBACK or mid-FILL: the transaction is abandoned and pmem signals are 0 the next cycle. Memory must tolerate a dropped request; the CPU must re-issue.
- A pmem_resp arriving in IDLE or COMPARE is ignored.
- Back-to-back requests: a new request is accepted in the IDLE cycle after mem_resp. Throughput is one hit per 2 cycles.

Decomposition:
Package dcache_types:
- S_INDEX-derived widths (TAG_W, SET_W).
- Line type (256-bit).
- State enum {IDLE, COMPARE, WRITEBACK, FILL}.
- Line-address helper constants.

Sub-module dcache_array:
- Per-set valid, dirty, tag and data storage with synchronous write and combinational read.
- 32-bit byte-mask write port for write hits; full-line write for fills.

Test Plan:
- Cold read 0x0000_0104 -> pmem_read with pmem_address=0x0000_0100; return line with word1=0xDEADBEEF -> mem_rdata=0xDEADBEEF, mem_resp 2 cycles after pmem_resp.
- Hit after fill: read 0x0000_0108 -> mem_resp the cycle after request, no pmem activity.
- Write 0x0000_0104, be=4'b0011, wdata=0x1234_5678 -> read returns 0xDEAD5678; dirty set.
- Conflict read 0x0000_1104 (same set, new tag) -> pmem_write first with pmem_address=0x0000_0100 and evicted word1=0xDEAD5678, then pmem_read at 0x0000_1100.
- Assert rst during FILL before pmem_resp -> next cycle pmem_read=0, mem_resp=0; re-read of 0x0000_0104 misses (valid cleared).
- 100 random read/write mix checked against a flat memory model -> all mem_rdata match; pmem_read and pmem_write never overlap.

Source files
------------

// File: rtl/dcache_responder_pkg.sv
// Shared widths, types and helpers for the direct-mapped write-back data cache.
package dcache_types;

    localparam int S_INDEX_DEFAULT = 3;
    localparam int OFFSET_W        = 5;
    localparam int WORD_SEL_W      = 3;
    localparam int LINE_W          = 256;
    localparam int LINE_BYTES      = 32;
    localparam int SET_W           = S_INDEX_DEFAULT;
    localparam int TAG_W           = 32 - OFFSET_W - SET_W;

    localparam logic [OFFSET_W-1:0] LINE_OFFSET_ZERO = 5'd0;

    typedef logic [LINE_W-1:0] line_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        COMPARE   = 2'd1,
        WRITEBACK = 2'd2,
        FILL      = 2'd3
    } state_e;

    function automatic logic [31:0] line_word(input line_t line, input logic [WORD_SEL_W-1:0] word);
        return line[{word, 5'd0} +: 32];
    endfunction

    // Places a 4-lane word enable onto the 32 byte lanes of a line.
    function automatic logic [LINE_BYTES-1:0] word_byte_mask(input logic [WORD_SEL_W-1:0] word,
                                                             input logic [3:0] be);
        return {28'd0, be} << {word, 2'b00};
    endfunction

endpackage

// File: rtl/dcache_responder_if.sv
// CPU-side and physical-memory-side signals of the data cache.
interface dcache_responder_if;

    logic [31:0]         mem_address;
    logic                mem_read;
    logic                mem_write;
    logic [3:0]          mem_byte_enable;
    logic [31:0]         mem_wdata;
    logic [31:0]         mem_rdata;
    logic                mem_resp;

    logic [31:0]         pmem_address;
    logic                pmem_read;
    logic                pmem_write;
    dcache_types::line_t pmem_wdata;
    dcache_types::line_t pmem_rdata;
    logic                pmem_resp;

    modport master (
        output mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
        input  mem_rdata, mem_resp,
        input  pmem_address, pmem_read, pmem_write, pmem_wdata,
        output pmem_rdata, pmem_resp
    );

    modport slave (
        input  mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
        output mem_rdata, mem_resp,
        output pmem_address, pmem_read, pmem_write, pmem_wdata,
        input  pmem_rdata, pmem_resp
    );

endinterface

// File: rtl/dcache_responder_array.sv
// Per-set valid/dirty/tag/data storage: combinational read, synchronous writes.
module dcache_array
    import dcache_types::*;
#(
    parameter int S_INDEX = S_INDEX_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [S_INDEX-1:0]        set_idx,
    output logic                      valid,
    output logic                      dirty,
    output logic [31-OFFSET_W-S_INDEX:0] tag,
    output line_t                     line,
    input  logic                      hit_we,
    input  logic [LINE_BYTES-1:0]     byte_mask,
    input  line_t                     hit_line,
    input  logic                      fill_we,
    input  logic [31-OFFSET_W-S_INDEX:0] fill_tag,
    input  line_t                     fill_line
);

    localparam int SETS     = 1 << S_INDEX;
    localparam int TAG_BITS = 32 - OFFSET_W - S_INDEX;

    logic [SETS-1:0]     valid_r;
    logic [SETS-1:0]     dirty_r;
    logic [TAG_BITS-1:0] tag_r  [SETS];
    line_t               data_r [SETS];

    assign valid = valid_r[set_idx];
    assign dirty = dirty_r[set_idx];
    assign tag   = tag_r[set_idx];
    assign line  = data_r[set_idx];

    // Status bits: cleared by reset, set valid/clean on fill, dirty on write hit.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r <= {SETS{1'b0}};
            dirty_r <= {SETS{1'b0}};
        end else if (fill_we) begin
            valid_r[set_idx] <= 1'b1;
            dirty_r[set_idx] <= 1'b0;
        end else if (hit_we) begin
            dirty_r[set_idx] <= 1'b1;
        end
    end

    // Tag and data storage; deliberately not cleared by reset.
    always_ff @(posedge clk) begin
        if (fill_we) begin
            tag_r[set_idx]  <= fill_tag;
            data_r[set_idx] <= fill_line;
        end else if (hit_we) begin
            for (int b = 0; b < LINE_BYTES; b++) begin
                if (byte_mask[b]) begin
                    data_r[set_idx][b*8 +: 8] <= hit_line[b*8 +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/dcache_responder.sv
// Direct-mapped, write-back, write-allocate data cache between the MEM stage and line memory.
module dcache_responder
    import dcache_types::*;
#(
    parameter int S_INDEX = S_INDEX_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    dcache_responder_if.slave  bus
);

    localparam int TAG_BITS = 32 - OFFSET_W - S_INDEX;

    state_e                state_r, state_next_s;
    logic                  mem_resp_r, resp_next_s;
    logic [31:0]           mem_rdata_r, rdata_next_s;
    logic                  pmem_read_r, pread_next_s;
    logic                  pmem_write_r, pwrite_next_s;
    logic [31:0]           pmem_address_r, paddr_next_s;
    line_t                 pmem_wdata_r, pwdata_next_s;

    logic [WORD_SEL_W-1:0] addr_word_s;
    logic [S_INDEX-1:0]    addr_set_s;
    logic [TAG_BITS-1:0]   addr_tag_s;
    logic                  req_s, is_write_s, hit_s;
    logic                  arr_valid_s, arr_dirty_s;
    logic [TAG_BITS-1:0]   arr_tag_s;
    line_t                 arr_line_s;
    logic [31:0]           hit_word_s;
    logic                  hit_we_s, fill_we_s;
    logic [1:0]            unused_addr_s;

    assign addr_word_s   = bus.mem_address[4:2];
    assign addr_set_s    = bus.mem_address[OFFSET_W +: S_INDEX];
    assign addr_tag_s    = bus.mem_address[31 -: TAG_BITS];
    assign unused_addr_s = bus.mem_address[1:0];
    assign req_s         = bus.mem_read | bus.mem_write;
    assign is_write_s    = bus.mem_write;
    assign hit_s         = arr_valid_s && (arr_tag_s == addr_tag_s);
    assign hit_word_s    = line_word(arr_line_s, addr_word_s);

    dcache_array #(.S_INDEX(S_INDEX)) u_array (
        .clk       (clk),
        .rst       (rst),
        .set_idx   (addr_set_s),
        .valid     (arr_valid_s),
        .dirty     (arr_dirty_s),
        .tag       (arr_tag_s),
        .line      (arr_line_s),
        .hit_we    (hit_we_s),
        .byte_mask (word_byte_mask(addr_word_s, bus.mem_byte_enable)),
        .hit_line  ({8{bus.mem_wdata}}),
        .fill_we   (fill_we_s),
        .fill_tag  (addr_tag_s),
        .fill_line (bus.pmem_rdata)
    );

    // Next state and next registered outputs. mem_resp is decided one cycle
    // early so the pulse lines up with the COMPARE cycle that owns it; after a
    // fill, COMPARE spends one cycle to arm the pulse and one to present it.
    always_comb begin
        state_next_s  = state_r;
        resp_next_s   = 1'b0;
        rdata_next_s  = mem_rdata_r;
        pread_next_s  = 1'b0;
        pwrite_next_s = 1'b0;
        paddr_next_s  = pmem_address_r;
        pwdata_next_s = pmem_wdata_r;
        hit_we_s      = 1'b0;
        fill_we_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (req_s) begin
                    state_next_s = COMPARE;
                    resp_next_s  = hit_s;
                    rdata_next_s = hit_word_s;
                end else begin
                    state_next_s = IDLE;
                end
            end
            COMPARE: begin
                if (mem_resp_r) begin
                    state_next_s = IDLE;
                    hit_we_s     = is_write_s;
                end else if (hit_s) begin
                    state_next_s = COMPARE;
                    resp_next_s  = 1'b1;
                    rdata_next_s = hit_word_s;
                end else if (arr_valid_s && arr_dirty_s) begin
                    state_next_s  = WRITEBACK;
                    pwrite_next_s = 1'b1;
                    paddr_next_s  = {arr_tag_s, addr_set_s, LINE_OFFSET_ZERO};
                    pwdata_next_s = arr_line_s;
                end else begin
                    state_next_s = FILL;
                    pread_next_s = 1'b1;
                    paddr_next_s = {addr_tag_s, addr_set_s, LINE_OFFSET_ZERO};
                end
            end
            WRITEBACK: begin
                if (bus.pmem_resp) begin
                    state_next_s = FILL;
                    pread_next_s = 1'b1;
                    paddr_next_s = {addr_tag_s, addr_set_s, LINE_OFFSET_ZERO};
                end else begin
                    state_next_s  = WRITEBACK;
                    pwrite_next_s = 1'b1;
                end
            end
            FILL: begin
                if (bus.pmem_resp) begin
                    state_next_s = COMPARE;
                    fill_we_s    = 1'b1;
                end else begin
                    state_next_s = FILL;
                    pread_next_s = 1'b1;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= IDLE;
            mem_resp_r     <= 1'b0;
            mem_rdata_r    <= 32'd0;
            pmem_read_r    <= 1'b0;
            pmem_write_r   <= 1'b0;
            pmem_address_r <= 32'd0;
            pmem_wdata_r   <= {LINE_W{1'b0}};
        end else begin
            state_r        <= state_next_s;
            mem_resp_r     <= resp_next_s;
            mem_rdata_r    <= rdata_next_s;
            pmem_read_r    <= pread_next_s;
            pmem_write_r   <= pwrite_next_s;
            pmem_address_r <= paddr_next_s;
            pmem_wdata_r   <= pwdata_next_s;
        end
    end

    assign bus.mem_resp     = mem_resp_r;
    assign bus.mem_rdata    = mem_rdata_r;
    assign bus.pmem_read    = pmem_read_r;
    assign bus.pmem_write   = pmem_write_r;
    assign bus.pmem_address = pmem_address_r;
    assign bus.pmem_wdata   = pmem_wdata_r;

endmodule
